out_mapper: RTL and testbench

- Return-path counterpart of the AER-to-SpiNNaker input mapper.
- Accepts 72-bit SpiNNaker packets from the SpiNNaker receiver, checks odd parity and packet type, and strips the header.
- Buffers multicast routing keys in a small FIFO and presents them as events on the output AER device interface.
- Dumps packets when the AER device stops responding, so the SpiNNaker link never stalls.

---
 rtl/out_mapper_if.sv | 44 ++++
 rtl/out_mapper.sv | 184 ++++++++++++++++++
 tb/tb_out_mapper.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/out_mapper_if.sv
//============================================================================
// Module      : out_mapper_if
// Description : Packet-in / AER-event-out handshake bundle for out_mapper.
//               The slave modport is the mapper's view; master is the
//               surrounding environment (SpiNNaker receiver + AER device).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface out_mapper_if #(
    parameter int AER_WIDTH = 32
) ();

    // SpiNNaker packet side
    logic [71:0]          opkt_data;
    logic                 opkt_vld;
    logic                 opkt_rdy;

    // AER event side
    logic [AER_WIDTH-1:0] oaer_data;
    logic                 oaer_vld;
    logic                 oaer_rdy;

    modport master (
        output opkt_data,
        output opkt_vld,
        input  opkt_rdy,
        input  oaer_data,
        input  oaer_vld,
        output oaer_rdy
    );

    modport slave (
        input  opkt_data,
        input  opkt_vld,
        output opkt_rdy,
        output oaer_data,
        output oaer_vld,
        input  oaer_rdy
    );

endinterface

`default_nettype wire

// File: rtl/out_mapper.sv
//============================================================================
// Module      : out_mapper
// Description : Return-path mapper. Accepts 72-bit SpiNNaker packets,
//               checks odd parity and multicast type, buffers routing keys
//               in a small FIFO and presents them as AER events. When the
//               AER device stops responding the mapper enters dump mode and
//               discards incoming packets so the SpiNNaker link never stalls.
//               Optional feature macro: OUT_MAPPER_ERR_CNT_EN adds the
//               parity_err_cnt / drop_cnt saturating counter ports.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module out_mapper #(
    parameter int AER_WIDTH   = 32,   // 1..32
    parameter int FIFO_DEPTH  = 4,    // 2..16
    parameter int DUMP_CYCLES = 128   // 1..255
) (
    input  wire logic        clk,
    input  wire logic        rst,
    out_mapper_if.slave      bus,
    output logic             dump_mode
`ifdef OUT_MAPPER_ERR_CNT_EN
    ,
    output logic [15:0]      parity_err_cnt,
    output logic [15:0]      drop_cnt
`endif
);

    //------------------------------------------------------------------------
    // Constants
    //------------------------------------------------------------------------
    localparam int              c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]      c_DUMP_LOAD = 8'(DUMP_CYCLES);
    localparam logic [1:0]      c_TYPE_MC   = 2'b00;

    //------------------------------------------------------------------------
    // State
    //------------------------------------------------------------------------
    logic [AER_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [7:0]           r_dump_cnt;
    logic                 r_dump_mode;

    //------------------------------------------------------------------------
    // Packet decode
    //------------------------------------------------------------------------
    logic                 w_payload_flag;
    logic [1:0]           w_type;
    logic [31:0]          w_key;
    logic                 w_parity_ok;
    logic                 w_is_mc;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pkt_accept;
    logic                 w_push;
    logic                 w_pop;

    assign w_payload_flag = bus.opkt_data[1];
    assign w_type         = bus.opkt_data[7:6];
    assign w_key          = bus.opkt_data[39:8];

    // Odd parity: the parity bit makes the XOR over the covered span equal 1.
    // The payload word only participates when the payload flag is set.
    assign w_parity_ok    = w_payload_flag ? (^bus.opkt_data[71:0])
                                           : (^bus.opkt_data[39:0]);
    assign w_is_mc        = (w_type == c_TYPE_MC);

    assign w_fifo_full    = (r_count == c_FULL_CNT);
    assign w_fifo_empty   = (r_count == '0);

    // Ready depends on registered state only; a pop pending while full does
    // not open the door in the same cycle.
    assign bus.opkt_rdy   = ~w_fifo_full | r_dump_mode;

    assign w_pkt_accept   = bus.opkt_vld & bus.opkt_rdy;
    assign w_push         = w_pkt_accept & w_parity_ok & w_is_mc & ~r_dump_mode;
    assign w_pop          = ~w_fifo_empty & bus.oaer_rdy;

    // Output is the FIFO head, forced to zero while empty so no stale key is
    // ever visible on the AER bus.
    assign bus.oaer_vld   = ~w_fifo_empty;
    assign bus.oaer_data  = w_fifo_empty ? '0 : r_mem[r_rd_ptr];

    assign dump_mode      = r_dump_mode;

    //------------------------------------------------------------------------
    // Circular pointer advance with wrap at FIFO_DEPTH-1 (depth need not be
    // a power of two).
    //------------------------------------------------------------------------
    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Key storage: written on push only; contents are don't-care when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_key[AER_WIDTH-1:0];
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the
    // occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Dead-device watchdog: counts consecutive oaer_rdy-low cycles down to
    // zero, then flags dump mode. Any ready cycle reloads and clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dump_cnt  <= c_DUMP_LOAD;
            r_dump_mode <= 1'b0;
        end else if (bus.oaer_rdy) begin
            r_dump_cnt  <= c_DUMP_LOAD;
            r_dump_mode <= 1'b0;
        end else if (r_dump_cnt != 8'd0) begin
            r_dump_cnt  <= r_dump_cnt - 8'd1;
            r_dump_mode <= 1'b0;
        end else begin
            r_dump_cnt  <= r_dump_cnt;
            r_dump_mode <= 1'b1;
        end
    end

`ifdef OUT_MAPPER_ERR_CNT_EN
    //------------------------------------------------------------------------
    // Error statistics. A parity failure is attributed to parity only, even
    // when the packet would also have been dropped for type or dump mode.
    //------------------------------------------------------------------------
    logic        w_parity_evt;
    logic        w_drop_evt;
    logic [15:0] r_parity_err_cnt;
    logic [15:0] r_drop_cnt;

    assign w_parity_evt = w_pkt_accept & ~w_parity_ok;
    assign w_drop_evt   = w_pkt_accept & w_parity_ok & (~w_is_mc | r_dump_mode);

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err_cnt <= '0;
            r_drop_cnt       <= '0;
        end else begin
            if (w_parity_evt && (r_parity_err_cnt != 16'hFFFF)) begin
                r_parity_err_cnt <= r_parity_err_cnt + 16'd1;
            end
            if (w_drop_evt && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign parity_err_cnt = r_parity_err_cnt;
    assign drop_cnt       = r_drop_cnt;
`else
    // Without the statistics feature the discard behaviour is identical;
    // only the counters and their ports are absent.
`endif

endmodule

`default_nettype wire

// File: tb/tb_out_mapper.sv
//============================================================================
// Module      : tb_out_mapper
// Description : Directed self-checking bench for out_mapper (default
//               parameters: AER_WIDTH=32, FIFO_DEPTH=4, DUMP_CYCLES=128).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_out_mapper;

    localparam int c_DUMP_CYCLES = 128;

    logic clk;
    logic rst;
    logic dump_mode;
`ifdef OUT_MAPPER_ERR_CNT_EN
    logic [15:0] parity_err_cnt;
    logic [15:0] drop_cnt;
`endif

    out_mapper_if #(.AER_WIDTH(32)) bus ();

    out_mapper #(
        .AER_WIDTH   (32),
        .FIFO_DEPTH  (4),
        .DUMP_CYCLES (c_DUMP_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .dump_mode      (dump_mode)
`ifdef OUT_MAPPER_ERR_CNT_EN
        ,
        .parity_err_cnt (parity_err_cnt),
        .drop_cnt       (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] q[$];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Multicast-style packet with correct odd parity, payload flag 0.
    function automatic logic [71:0] mk_pkt(input logic [31:0] key, input logic [1:0] typ);
        logic [71:0] p;
        p       = '0;
        p[39:8] = key;
        p[7:6]  = typ;
        p[0]    = ~(^p[39:1]);
        return p;
    endfunction

    // Offer one packet; returns 1ns after the consuming edge.
    task automatic send(input logic [71:0] pkt);
        bit done;
        done = 0;
        bus.opkt_data = pkt;
        bus.opkt_vld  = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.opkt_rdy) done = 1;
            @(posedge clk);
        end
        #1;
        bus.opkt_vld = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    // Raise oaer_rdy and record n events in q.
    task automatic collect(input int n);
        int got;
        got = 0;
        q.delete();
        bus.oaer_rdy = 1'b1;
        for (int i = 0; i < 40 && got < n; i++) begin
            @(negedge clk);
            if (bus.oaer_vld) begin
                q.push_back(bus.oaer_data);
                got++;
            end
            @(posedge clk);
            #1;
        end
        if (got != n) check("collect_timeout", 72'(got), 72'(n));
    endtask

    initial begin
        int start;
        int seen;
        rst           = 1'b1;
        bus.opkt_data = '0;
        bus.opkt_vld  = 1'b0;
        bus.oaer_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld_async", 72'(bus.oaer_vld), 0);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_vld",  72'(bus.oaer_vld), 0);
        check("rst_data", 72'(bus.oaer_data), 0);
        check("rst_dump", 72'(dump_mode), 0);
        check("rst_rdy",  72'(bus.opkt_rdy), 1);
`ifdef OUT_MAPPER_ERR_CNT_EN
        check("rst_perr", 72'(parity_err_cnt), 0);
        check("rst_drop", 72'(drop_cnt), 0);
`endif
        @(posedge clk);
        #1;

        // Single good packet: key 0x1, visible right after the accept edge
        send(72'h00_0000_0000_0000_0100);
        check("single_vld",  72'(bus.oaer_vld), 1);
        check("single_data", 72'(bus.oaer_data), 72'h1);
        @(posedge clk);
        #1;
        check("single_pulse", 72'(bus.oaer_vld), 0);

        // Parity error
        send(72'h00_0000_0000_0000_0101);
        @(negedge clk);
        check("perr_vld", 72'(bus.oaer_vld), 0);
`ifdef OUT_MAPPER_ERR_CNT_EN
        check("perr_cnt",  72'(parity_err_cnt), 1);
        check("perr_drop", 72'(drop_cnt), 0);
`endif
        @(posedge clk);
        #1;

        // Non-multicast: key 0x3, type 01, parity valid
        send(72'h00_0000_0000_0000_0340);
        @(negedge clk);
        check("nmc_vld", 72'(bus.oaer_vld), 0);
`ifdef OUT_MAPPER_ERR_CNT_EN
        check("nmc_drop", 72'(drop_cnt), 1);
        check("nmc_perr", 72'(parity_err_cnt), 1);
`endif
        @(posedge clk);
        #1;

        // Back-pressure: 4 keys fill the FIFO, fifth waits for a pop
        bus.oaer_rdy = 1'b0;
        for (int k = 0; k < 4; k++) send(mk_pkt(32'h10 + 32'(k), 2'b00));
        check("bp_rdy_full", 72'(bus.opkt_rdy), 0);
        check("bp_head",     72'(bus.oaer_data), 72'h10);
        fork
            send(mk_pkt(32'h14, 2'b00));
            collect(5);
        join
        for (int k = 0; k < 5; k++)
            check($sformatf("bp_order%0d", k), 72'((k < q.size()) ? q[k] : 32'hDEAD), 72'h10 + 72'(k));
        @(negedge clk);
        check("bp_empty", 72'(bus.oaer_vld), 0);
        @(posedge clk);
        #1;

        // Dump: fill, then keep oaer_rdy low until the watchdog fires
        bus.oaer_rdy = 1'b0;
        start = cyc;
        for (int k = 0; k < 4; k++) send(mk_pkt(32'h20 + 32'(k), 2'b00));
        check("dump_full_rdy", 72'(bus.opkt_rdy), 0);
        for (int i = 0; i < 300 && !dump_mode; i++) begin
            @(posedge clk);
            #1;
        end
        check("dump_latency", 72'(cyc - start), 72'(c_DUMP_CYCLES + 1));
        check("dump_rdy", 72'(bus.opkt_rdy), 1);
        send(mk_pkt(32'h99, 2'b00));
        check("dump_hold_vld",  72'(bus.oaer_vld), 1);
        check("dump_hold_data", 72'(bus.oaer_data), 72'h20);
`ifdef OUT_MAPPER_ERR_CNT_EN
        check("dump_drop", 72'(drop_cnt), 2);
`endif
        @(posedge clk);
        #1;
        collect(4);
        for (int k = 0; k < 4; k++)
            check($sformatf("dump_drain%0d", k), 72'((k < q.size()) ? q[k] : 32'hDEAD), 72'h20 + 72'(k));
        check("dump_clear", 72'(dump_mode), 0);
        @(negedge clk);
        check("dump_no_stale", 72'(bus.oaer_vld), 0);
        @(posedge clk);
        #1;

        // Async reset with 3 keys queued
        bus.oaer_rdy = 1'b0;
        for (int k = 0; k < 3; k++) send(mk_pkt(32'h30 + 32'(k), 2'b00));
        check("ar_queued", 72'(bus.oaer_vld), 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_vld",  72'(bus.oaer_vld), 0);
        check("ar_dump", 72'(dump_mode), 0);
        check("ar_rdy",  72'(bus.opkt_rdy), 1);
`ifdef OUT_MAPPER_ERR_CNT_EN
        check("ar_cnts", 72'({parity_err_cnt, drop_cnt}), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.oaer_rdy = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.oaer_vld) seen++;
        end
        check("ar_no_stale", 72'(seen), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
